// File: rtl/bfp16_ws_col_loader.sv
// Feed side of a weight-stationary BFP16 PE column.
// Buffers one tile of weights, bursts them into the column shift chain,
// then holds while streaming ifmap vectors, drains the psums and pulses done.
// The weight buffer keeps accepting the next tile while the current one computes.
module bfp16_ws_col_loader #(
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = DEPTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  output logic                  busy,
  output logic                  done,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [15:0]           w_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [16*DEPTH-1:0]   x_data,
  output logic                  ctrl,
  output logic [15:0]           weight,
  output logic [16*DEPTH-1:0]   ifmap,
  output logic                  ifmap_vld
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [15:0]          wbuf_reg [DEPTH];
  logic [CNT_W-1:0]     num_vec_reg, num_vec_next;
  logic [CNT_W-1:0]     vec_cnt_reg, vec_cnt_next;
  logic [IW-1:0]        shift_idx_reg, shift_idx_next;
  logic [DW-1:0]        drain_cnt_reg, drain_cnt_next;
  logic                 ctrl_reg, ctrl_next;
  logic [15:0]          weight_reg, weight_next;
  logic [16*DEPTH-1:0]  ifmap_reg, ifmap_next;
  logic                 ifmap_vld_reg, ifmap_vld_next;
  logic                 done_reg, done_next;
  logic                 w_accept;
  logic                 x_accept;

  // Handshakes: the buffer is closed only while it is being shifted out;
  // vectors are taken only in COMPUTE and never beyond num_vec.
  assign w_ready  = (count_reg < CW'(DEPTH)) && (state_reg != S_SHIFT);
  assign x_ready  = (state_reg == S_COMPUTE) && (vec_cnt_reg < num_vec_reg);
  assign w_accept = w_valid && w_ready;
  assign x_accept = x_valid && x_ready;

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign ctrl      = ctrl_reg;
  assign weight    = weight_reg;
  assign ifmap     = ifmap_reg;
  assign ifmap_vld = ifmap_vld_reg;

  // Beat k of a tile lands in slot k; the slot is chosen by the fill count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wbuf
      always_ff @(posedge clk) begin
        if (w_accept && (count_reg == CW'(gi))) begin
          wbuf_reg[gi] <= w_data;
        end
      end
    end
  endgenerate

  // Next-state and next-output logic; column outputs default to HOLD/idle bus.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg + CW'(w_accept);
    num_vec_next   = num_vec_reg;
    vec_cnt_next   = vec_cnt_reg;
    shift_idx_next = '0;
    drain_cnt_next = '0;
    ctrl_next      = 1'b1;
    weight_next    = weight_reg;
    ifmap_next     = '0;
    ifmap_vld_next = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          num_vec_next = num_vec;
          vec_cnt_next = '0;
          state_next   = (count_reg == CW'(DEPTH)) ? S_SHIFT : S_FILL;
        end
      end
      S_FILL: begin
        if (count_next == CW'(DEPTH)) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Last buffered weight goes in first so buf[0] ends up at PE0.
        ctrl_next      = 1'b0;
        weight_next    = wbuf_reg[IW'(DEPTH - 1) - shift_idx_reg];
        shift_idx_next = shift_idx_reg + IW'(1);
        if (shift_idx_reg == IW'(DEPTH - 1)) begin
          shift_idx_next = '0;
          count_next     = '0;
          state_next     = (num_vec_reg == '0) ? S_DRAIN : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (x_accept) begin
          ifmap_next     = x_data;
          ifmap_vld_next = 1'b1;
          vec_cnt_next   = vec_cnt_reg + CNT_W'(1);
          // Compare against num_vec-1 so the counter never needs to exceed num_vec.
          if (vec_cnt_reg == num_vec_reg - CNT_W'(1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_next = drain_cnt_reg + DW'(1);
        if (drain_cnt_reg == DW'(DRAIN_CYC - 1)) begin
          drain_cnt_next = '0;
          done_next      = 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered column-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      num_vec_reg   <= '0;
      vec_cnt_reg   <= '0;
      shift_idx_reg <= '0;
      drain_cnt_reg <= '0;
      ctrl_reg      <= 1'b1;
      weight_reg    <= '0;
      ifmap_reg     <= '0;
      ifmap_vld_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      num_vec_reg   <= num_vec_next;
      vec_cnt_reg   <= vec_cnt_next;
      shift_idx_reg <= shift_idx_next;
      drain_cnt_reg <= drain_cnt_next;
      ctrl_reg      <= ctrl_next;
      weight_reg    <= weight_next;
      ifmap_reg     <= ifmap_next;
      ifmap_vld_reg <= ifmap_vld_next;
      done_reg      <= done_next;
    end
  end

endmodule
